// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writes a framed byte stream (header, words, checksum) into instruction memory.
// The processor core is held in reset until a load completes with a matching checksum. Rev 1.0
`default_nettype none

module instr_mem_loader #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Largest legal header byte: word count H+1 must fit the memory depth.
    localparam logic [8:0] MAX_HEADER = 9'((1 << ADDR_WIDTH) - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        DATA   = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [1:0]            byte_idx;
    logic [23:0]           word_buf;
    logic [7:0]            checksum;
    logic                  accept;
    logic                  load_start;
    logic                  header_overflow;

    assign in_ready        = (state == HEADER) || (state == DATA) || (state == CHECK);
    assign accept          = in_valid && in_ready;
    assign load_start      = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign header_overflow = ({1'b0, in_data} > MAX_HEADER);

    assign busy       = in_ready;
    assign done       = (state == DONE);
    assign error      = (state == ERROR);
    assign core_reset = (state != DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = HEADER;
            end
            HEADER: begin
                if (accept) state_next = header_overflow ? ERROR : DATA;
            end
            DATA: begin
                // Leave as the final byte of the last word is taken; its write lands in CHECK.
                if (accept && (byte_idx == 2'd3) && (word_idx == last_idx)) state_next = CHECK;
            end
            CHECK: begin
                if (accept) state_next = (in_data == checksum) ? DONE : ERROR;
            end
            DONE, ERROR: begin
                if (start) state_next = HEADER;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_idx  <= '0;
            last_idx  <= '0;
            byte_idx  <= 2'd0;
            word_buf  <= 24'd0;
            checksum  <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            if (load_start) begin
                word_idx <= '0;
                byte_idx <= 2'd0;
                word_buf <= 24'd0;
                checksum <= 8'd0;
            end
            if ((state == HEADER) && accept) begin
                last_idx <= in_data[ADDR_WIDTH-1:0];
            end
            if ((state == DATA) && accept) begin
                checksum <= checksum ^ in_data;
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: word_buf[7:0]   <= in_data;
                    2'd1: word_buf[15:8]  <= in_data;
                    2'd2: word_buf[23:16] <= in_data;
                    default: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_idx;
                        mem_wdata <= {in_data, word_buf};
                        word_idx  <= word_idx + 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table-driven loads, hand sequences and random loads vs a stream model.
`default_nettype none

module tb_instr_mem_loader;

    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          error;

    instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic [7:0]  hdr;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nw;
        logic [7:0]  chk;
        int          gap;
        bit          exp_done;
        bit          exp_err;
        int          exp_nwr;
    } vec_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    bit         exp_done;
    bit         exp_err;
    bit         exp_ovf;
    int         checks = 0;
    int         passes = 0;
    vec_t       vecs[6];
    logic [7:0] stream[$];

    // Every write strobe is captured once; mem_we is a full-cycle pulse.
    always @(negedge clock) begin
        if (mem_we) got_q.push_back('{addr: mem_addr, data: mem_wdata});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Reference: interpret the whole byte stream at once.
    task automatic model(input logic [7:0] s[$]);
        int         n;
        logic [7:0] x;
        logic [31:0] w;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_ovf  = 1'b0;
        n = int'(s[0]) + 1;
        if (n > (1 << AW)) begin
            exp_err = 1'b1;
            exp_ovf = 1'b1;
            return;
        end
        x = 8'd0;
        for (int k = 0; k < n; k++) begin
            w = {s[4*k+4], s[4*k+3], s[4*k+2], s[4*k+1]};
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            exp_q.push_back('{addr: AW'(k), data: w});
        end
        if (s[4*n+1] == x) exp_done = 1'b1;
        else exp_err = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called and returns at a negedge; leaves in_valid high with the sent byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clock);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            check("in_ready wait timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(negedge clock);
        end
    endtask

    task automatic run_stream(input logic [7:0] s[$], input int gap, input int start_at, input string tag);
        int base;
        model(s);
        base = got_q.size();
        pulse_start();
        check($sformatf("%s core_reset after start", tag), {31'd0, core_reset}, 32'd1);
        check($sformatf("%s busy after start", tag), {31'd0, busy}, 32'd1);
        check($sformatf("%s done after start", tag), {31'd0, done}, 32'd0);
        check($sformatf("%s error after start", tag), {31'd0, error}, 32'd0);
        for (int i = 0; i < s.size(); i++) begin
            if (i == start_at && i > 0) begin
                in_valid = 1'b0;
                pulse_start();
            end
            send_byte(s[i], (i == 0) ? 0 : gap);
            if (i == 0 && exp_ovf) begin
                check($sformatf("%s overflow error next cycle", tag), {31'd0, error}, 32'd1);
                check($sformatf("%s overflow in_ready", tag), {31'd0, in_ready}, 32'd0);
            end
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check($sformatf("%s write count", tag), got_q.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size() && (base + k) < got_q.size(); k++) begin
            check($sformatf("%s write addr %0d", tag, k), 32'(got_q[base+k].addr), 32'(exp_q[k].addr));
            check($sformatf("%s write data %0d", tag, k), got_q[base+k].data, exp_q[k].data);
        end
        check($sformatf("%s done", tag), {31'd0, done}, {31'd0, exp_done});
        check($sformatf("%s error", tag), {31'd0, error}, {31'd0, exp_err});
        check($sformatf("%s core_reset", tag), {31'd0, core_reset}, {31'd0, !exp_done});
        check($sformatf("%s busy", tag), {31'd0, busy}, 32'd0);
    endtask

    task automatic build(input vec_t v);
        logic [31:0] w;
        stream.delete();
        stream.push_back(v.hdr);
        for (int k = 0; k < v.nw; k++) begin
            w = (k == 0) ? v.w0 : v.w1;
            for (int b = 0; b < 4; b++) stream.push_back(w[8*b +: 8]);
        end
        if (v.nw > 0) stream.push_back(v.chk);
    endtask

    task automatic good_stream();
        stream = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h20};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          base;
        logic [7:0]  x;
        logic [7:0]  hdr;
        logic [31:0] w;

        vecs[0] = '{8'h01, 32'h00000013, 32'h00A00093, 2, 8'h20, 0, 1'b1, 1'b0, 2};
        vecs[1] = '{8'h01, 32'h00000013, 32'h00A00093, 2, 8'h21, 0, 1'b0, 1'b1, 2};
        vecs[2] = '{8'h10, 32'h0,        32'h0,        0, 8'h00, 0, 1'b0, 1'b1, 0};
        vecs[3] = '{8'h01, 32'h00000013, 32'h00A00093, 2, 8'h20, 3, 1'b1, 1'b0, 2};
        vecs[4] = '{8'h00, 32'h00000137, 32'h0,        1, 8'h36, 1, 1'b1, 1'b0, 1};
        vecs[5] = '{8'hFF, 32'h0,        32'h0,        0, 8'h00, 0, 1'b0, 1'b1, 0};

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clock);
        check("reset core_reset", {31'd0, core_reset}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset error", {31'd0, error}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        check("reset mem_we", {31'd0, mem_we}, 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle in_ready", {31'd0, in_ready}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            build(vecs[i]);
            base = got_q.size();
            run_stream(stream, vecs[i].gap, -1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table writes", i), got_q.size() - base, vecs[i].exp_nwr);
            check($sformatf("vec%0d table done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
            check($sformatf("vec%0d table error", i), {31'd0, error}, {31'd0, vecs[i].exp_err});
        end

        // start pulsed mid-load is ignored.
        good_stream();
        run_stream(stream, 0, 4, "start ignored");

        // Bytes offered in DONE are not consumed.
        base = got_q.size();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(negedge clock);
        check("done in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        @(negedge clock);
        check("done extra bytes no write", got_q.size() - base, 0);
        check("done holds", {31'd0, done}, 32'd1);

        // Reset after the 6th byte of a good load.
        good_stream();
        base = got_q.size();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stream[i], 0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("midreset core_reset", {31'd0, core_reset}, 32'd1);
        check("midreset mem_we", {31'd0, mem_we}, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        check("midreset mem_we hold", {31'd0, mem_we}, 32'd0);
        check("midreset writes", got_q.size() - base, 1);
        reset = 1'b0;
        @(negedge clock);
        run_stream(stream, 0, -1, "after reset");

        // Random loads, including a full-depth load.
        for (int r = 0; r < 24; r++) begin
            if (r == 0) hdr = 8'(((1 << AW) - 1));
            else if ($urandom_range(0, 7) == 0) hdr = 8'($urandom_range(16, 255));
            else hdr = 8'($urandom_range(0, 15));
            stream.delete();
            stream.push_back(hdr);
            if (int'(hdr) < (1 << AW)) begin
                x = 8'd0;
                for (int k = 0; k <= int'(hdr); k++) begin
                    w = $urandom;
                    for (int b = 0; b < 4; b++) begin
                        stream.push_back(w[8*b +: 8]);
                        x = x ^ w[8*b +: 8];
                    end
                end
                if (r != 0 && $urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
                stream.push_back(x);
            end
            run_stream(stream, $urandom_range(0, 2), -1, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
